// File: rtl/segsched_pkg.sv
// ============================================================================
//  segsched_pkg
//  Shared constants and types for the four-segment DMA write scheduler.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package segsched_pkg;

    localparam int NUM_SEGS = 4;
    localparam int CL_BYTES = 64;
    localparam int CL_SHIFT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Round-robin successor of a segment index, wrapping 3 -> 0.
    function automatic logic [1:0] seg_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  rr_arbiter
//  Combinational 4-way round-robin arbiter; the pointer register lives in the parent.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
    import segsched_pkg::*;
(
    input  logic [NUM_SEGS-1:0] i_req,
    input  logic [1:0]          i_ptr,
    input  logic                i_en,
    output logic [NUM_SEGS-1:0] o_grant,
    output logic [1:0]          o_idx
);

    logic [1:0] w_cand;
    logic       w_found;

    // Scan from the pointer upward; the first requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = 2'd0;
        w_cand  = 2'd0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            w_cand = i_ptr + 2'(i);
            if (i_en && !w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/segment_write_scheduler.sv
// ============================================================================
//  segment_write_scheduler
//  Arbitrates four segment producers onto one DMA write port and tracks completions.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module segment_write_scheduler
    import segsched_pkg::*;
#(
    parameter  int ADDR_WIDTH = 64,
    parameter  int DATA_WIDTH = 512,
    parameter  int SEG_LINES  = 16,
    localparam int LW_WIDTH   = $clog2(NUM_SEGS * SEG_LINES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] seg_base [NUM_SEGS],
    input  logic [NUM_SEGS-1:0]   seg_valid,
    input  logic [DATA_WIDTH-1:0] seg_data [NUM_SEGS],
    output logic [NUM_SEGS-1:0]   seg_ready,
    output logic                  dma_wr_en,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_wr_full,
    input  logic                  dma_wr_done,
    output logic                  done,
    output logic [LW_WIDTH-1:0]   lines_written
);

    localparam int                  IW          = $clog2(SEG_LINES + 1);
    localparam logic [IW-1:0]       c_SEG_LINES = IW'(SEG_LINES);
    localparam logic [IW-1:0]       c_SEG_LAST  = IW'(SEG_LINES - 1);
    localparam logic [LW_WIDTH-1:0] c_TOTAL     = LW_WIDTH'(NUM_SEGS * SEG_LINES);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_base   [NUM_SEGS];
    logic [IW-1:0]         r_issued [NUM_SEGS];
    logic [1:0]            r_ptr;
    logic [LW_WIDTH-1:0]   r_count;
    logic                  r_done;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic [NUM_SEGS-1:0]   w_req;
    logic [NUM_SEGS-1:0]   w_grant;
    logic [1:0]            w_gidx;
    logic                  w_arb_en;
    logic                  w_grant_vld;
    logic                  w_start;
    logic                  w_last_grant;
    logic                  w_count_en;
    logic [LW_WIDTH-1:0]   w_count_next;
    logic [ADDR_WIDTH-1:0] w_addr;

    generate
        for (genvar s = 0; s < NUM_SEGS; s++) begin : g_req
            assign w_req[s] = seg_valid[s] && (r_issued[s] < c_SEG_LINES);
        end
    endgenerate

    assign w_arb_en = (r_state == RUN) && !dma_wr_full;

    rr_arbiter u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign w_grant_vld = |w_grant;
    assign w_start     = go && ((r_state == IDLE) || (r_state == DONE));

    // Line k of a segment sits k cachelines above its base; overflow wraps silently.
    assign w_addr = r_base[w_gidx] + (ADDR_WIDTH'(r_issued[w_gidx]) << CL_SHIFT);

    // True when this cycle's grant leaves every segment fully issued.
    always_comb begin
        w_last_grant = w_grant_vld;
        for (int s = 0; s < NUM_SEGS; s++) begin
            if (!((r_issued[s] == c_SEG_LINES) ||
                  (w_grant[s] && (r_issued[s] == c_SEG_LAST)))) begin
                w_last_grant = 1'b0;
            end
        end
    end

    assign w_count_en   = ((r_state == RUN) || (r_state == DRAIN)) &&
                          dma_wr_done && (r_count != c_TOTAL);
    assign w_count_next = w_count_en ? (r_count + LW_WIDTH'(1)) : r_count;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (go) w_state_next = RUN;
            RUN:        if (w_last_grant) w_state_next = DRAIN;
            DRAIN:      if (w_count_next == c_TOTAL) w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SEGS; s++) begin
                r_base[s]   <= '0;
                r_issued[s] <= '0;
            end
            r_ptr     <= 2'd0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_grant_vld;
            if (w_grant_vld) begin
                r_wr_addr        <= w_addr;
                r_wr_data        <= seg_data[w_gidx];
                r_issued[w_gidx] <= r_issued[w_gidx] + IW'(1);
                r_ptr            <= seg_next(w_gidx);
            end
            // A start never coincides with a grant: grants only happen in RUN.
            if (w_start) begin
                for (int s = 0; s < NUM_SEGS; s++) begin
                    r_base[s]   <= seg_base[s];
                    r_issued[s] <= '0;
                end
                r_ptr   <= 2'd0;
                r_count <= '0;
            end else begin
                r_count <= w_count_next;
            end
            r_done <= (w_state_next == DONE);
        end
    end

    assign seg_ready     = w_grant;
    assign dma_wr_en     = r_wr_en;
    assign dma_wr_addr   = r_wr_addr;
    assign dma_wr_data   = r_wr_data;
    assign done          = r_done;
    assign lines_written = r_count;

endmodule

`default_nettype wire
